fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage: owns the PC, issues one instruction-memory request at a time and presents
//  the fetched word with its PC to decode through a valid/ready handshake. It is redirected by the
//  execute stage, where branch_unit resolves taken branches and jumps. A redirect flushes the held
//  instruction and drops any in-flight response. One outstanding request; multicycle-CPU throughput.
// PARAMETERS
//  INSTRUCTION_BITSIZE  32            width of PC, addresses and instruction words
//  RESET_PC             32'h0000_0000 first fetch address after reset (bits [1:0] must be 0)
// PORTS
//  clk              in   1   single clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  redirect_valid   in   1   execute stage: branch taken / jump, load new PC this cycle
//  redirect_target  in   W   new PC; bits [1:0] ignored (forced to 0)
//  imem_req_valid   out  1   request to instruction memory
//  imem_req_ready   in   1   memory accepts request when valid&ready
//  imem_req_addr    out  W   word-aligned fetch address (= pc)
//  imem_rsp_valid   in   1   one-cycle pulse, response data valid; no backpressure
//  imem_rsp_data    in   W   instruction word
//  if_valid         out  1   fetched instruction available to decode
//  if_ready         in   1   decode consumes when if_valid&if_ready
//  if_instr         out  W   instruction word
//  if_pc            out  W   PC of if_instr
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=REQ, drop=0, if_valid=0, if_instr=0,
//   if_pc=0, imem_req_valid=0 while rst_n=0. First request (addr RESET_PC) in first cycle after release.
//  States: REQ, WAIT, HOLD. All registered; imem_req_valid = (state==REQ); imem_req_addr = pc.
//  - REQ:  req_valid=1. On req_valid&req_ready -> WAIT. Address may change while unaccepted (redirect).
//  - WAIT: on rsp_valid: drop=1 -> discard, drop<=0, -> REQ; drop=0 -> if_instr<=rsp_data,
//          if_pc<=pc, if_valid<=1, pc<=pc+4, -> HOLD.
//  - HOLD: if_valid=1, outputs stable; on if_ready -> if_valid<=0, -> REQ.
//  Latency: request accepted at cycle N, response at N+k (k>=1) -> if_valid at N+k+1. Best case 3
//   cycles per instruction. rsp_valid outside WAIT is ignored (stale/spurious).
//  Redirect (highest priority, any state): pc<={target[W-1:2],2'b00}; if_valid<=0 (flush). Then:
//  - REQ, no handshake this cycle: stay REQ; next cycle addr = target.
//  - REQ, handshake same cycle: old address accepted; -> WAIT with drop<=1.
//  - WAIT, no rsp this cycle: stay WAIT, drop<=1.  WAIT, rsp same cycle: discard rsp, drop<=0, -> REQ.
//  - HOLD: held instr discarded even if if_ready=1 same cycle (no handshake counted); -> REQ.
//  - Redirect while drop=1: pc updated, drop stays 1; only one response is ever dropped.
//  pc+4 wraps modulo 2^W (0xFFFF_FFFC -> 0x0000_0000). No misaligned-target exception here.
//  Reset mid-operation: all state cleared immediately; a response arriving after release is
//   ignored because state is REQ.
// TESTING
//  1 Reset release, mem ready=1, 1-cycle rsp 0x00000013 -> req addr 0x0 in cycle 1; if_valid, instr
//    0x13, if_pc 0x0 in cycle 3; next req addr 0x4 after if_ready.
//  2 Decode stalls (if_ready=0 for 5 cycles) in HOLD -> if_valid/instr/pc stable, no new request.
//  3 Redirect to 0x100 in WAIT, rsp 2 cycles later -> rsp dropped, if_valid stays 0, next req 0x100.
//  4 Redirect to 0x203 coincident with req handshake at 0x8 -> response for 0x8 dropped; next req
//    addr 0x200; delivered if_pc 0x200.
//  5 Redirect to 0x40 in HOLD with if_ready=1 same cycle -> held instr flushed, next req addr 0x40.
//  6 RESET_PC=0xFFFF_FFFC -> second req addr 0x0; rst_n pulsed low in WAIT then rsp arrives ->
//    ignored, req at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and hands the fetched
// word plus its PC to decode over a valid/ready handshake; execute-stage redirects flush it.
module fetch_unit #(
  parameter int                             INSTRUCTION_BITSIZE = 32,
  parameter logic [INSTRUCTION_BITSIZE-1:0] RESET_PC            = {INSTRUCTION_BITSIZE{1'b0}}
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           redirect_valid,
  input  logic [INSTRUCTION_BITSIZE-1:0] redirect_target,
  output logic                           imem_req_valid,
  input  logic                           imem_req_ready,
  output logic [INSTRUCTION_BITSIZE-1:0] imem_req_addr,
  input  logic                           imem_rsp_valid,
  input  logic [INSTRUCTION_BITSIZE-1:0] imem_rsp_data,
  output logic                           if_valid,
  input  logic                           if_ready,
  output logic [INSTRUCTION_BITSIZE-1:0] if_instr,
  output logic [INSTRUCTION_BITSIZE-1:0] if_pc
);

  localparam int W = INSTRUCTION_BITSIZE;
  localparam logic [W-1:0] PC_STEP = {{(W-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         drop_q, drop_d;
  logic         active_q;
  logic         if_valid_q, if_valid_d;
  logic [W-1:0] if_instr_q, if_instr_d;
  logic [W-1:0] if_pc_q, if_pc_d;

  logic [W-1:0] redirect_pc_s;
  logic         req_fire_s;

  assign redirect_pc_s = {redirect_target[W-1:2], 2'b00};
  assign req_fire_s    = imem_req_valid & imem_req_ready;

  // State register; active_q keeps the request line low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      active_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_instr_q <= {W{1'b0}};
      if_pc_q    <= {W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      active_q   <= 1'b1;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  // Next-state and datapath update; a redirect overrides the PC in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = redirect_valid ? redirect_pc_s : pc_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      ST_REQ: begin
        if (req_fire_s) begin
          // The old address has already been accepted, so its response must be discarded.
          state_d = ST_WAIT;
          drop_d  = redirect_valid;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + PC_STEP;
            state_d    = ST_HOLD;
          end
        end else begin
          drop_d = drop_q | redirect_valid;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || if_ready) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d    = ST_REQ;
        drop_d     = 1'b0;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    imem_req_valid = active_q && (state_q == ST_REQ);
    imem_req_addr  = pc_q;
    if_valid       = if_valid_q;
    if_instr       = if_instr_q;
    if_pc          = if_pc_q;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a default-reset instance fed by a latency-programmable memory
// responder, and a second instance at the top of the address space for PC wrap and mid-wait reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n, redirect_valid, req_ready, rsp_valid, if_ready;
  logic [31:0] redirect_target, rsp_data;
  logic        req_valid, if_valid;
  logic [31:0] req_addr, if_instr, if_pc;

  logic        rst2_n, redirect2_valid, req2_ready, rsp2_valid, if2_ready;
  logic [31:0] redirect2_target, rsp2_data;
  logic        req2_valid, if2_valid;
  logic [31:0] req2_addr, if2_instr, if2_pc;

  int          pass_cnt, chk_cnt;
  int          lat, pend_cnt;
  logic [31:0] pend_addr;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
  );

  fetch_unit #(.INSTRUCTION_BITSIZE(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .redirect_valid(redirect2_valid), .redirect_target(redirect2_target),
    .imem_req_valid(req2_valid), .imem_req_ready(req2_ready), .imem_req_addr(req2_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .if_valid(if2_valid), .if_ready(if2_ready), .if_instr(if2_instr), .if_pc(if2_pc)
  );

  always #5 clk = ~clk;

  // Memory model for u_dut: instruction word = address + 0x13, delivered lat cycles after acceptance.
  initial begin
    pend_cnt = 0;
    pend_addr = 32'h0;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt = pend_cnt - 1;
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_data  = pend_addr + 32'h13;
        end
      end
      if (req_valid && req_ready) begin
        pend_cnt  = lat;
        pend_addr = req_addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) tick();
    chk_cnt++;
    if ({req_valid, if_valid, if_instr, if_pc, req_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0})
      $display("FAIL reset_state: got %b %b %h %h %h expected 0 0 0 0 0",
               req_valid, if_valid, if_instr, if_pc, req_addr);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    tick();
    chk_cnt++;
    if ({req_valid, req_addr, if_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL first_req: got valid=%b addr=%h if_valid=%b expected 1 0 0", req_valid, req_addr, if_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({req_valid, if_valid} !== 2'b00)
      $display("FAIL first_wait: got req=%b if_valid=%b expected 0 0", req_valid, if_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h0000_0013, 32'h0})
      $display("FAIL first_deliver: got %b %h %h expected 1 00000013 00000000", if_valid, if_instr, if_pc);
    else pass_cnt++;
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++;
      if ({if_valid, if_instr, if_pc, req_valid} !== {1'b1, 32'h0000_0013, 32'h0, 1'b0})
        $display("FAIL stall_hold[%0d]: got %b %h %h req=%b expected 1 00000013 00000000 0",
                 i, if_valid, if_instr, if_pc, req_valid);
      else pass_cnt++;
    end
    if_ready = 1'b1;
    tick();
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h4})
      $display("FAIL stall_release: got %b %b %h expected 0 1 00000004", if_valid, req_valid, req_addr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    tick();
    chk_cnt++;
    if (req_valid !== 1'b0)
      $display("FAIL b2b_wait: got req=%b expected 0", req_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h0000_0017, 32'h4})
      $display("FAIL b2b_deliver: got %b %h %h expected 1 00000017 00000004", if_valid, if_instr, if_pc);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h8})
      $display("FAIL b2b_next_req: got %b %b %h expected 0 1 00000008", if_valid, req_valid, req_addr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_handshake();
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if ({if_valid, req_valid} !== 2'b00)
      $display("FAIL rdh_wait: got if_valid=%b req=%b expected 0 0", if_valid, req_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL rdh_drop: got %b %b %h expected 0 1 00000200", if_valid, req_valid, req_addr);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (req_valid !== 1'b0)
      $display("FAIL rdh_wait2: got req=%b expected 0", req_valid);
    else pass_cnt++;
    tick();
    lat = 2;
    chk_cnt++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h0000_0213, 32'h200})
      $display("FAIL rdh_deliver: got %b %h %h expected 1 00000213 00000200", if_valid, if_instr, if_pc);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h204})
      $display("FAIL rdh_next_req: got %b %b %h expected 0 1 00000204", if_valid, req_valid, req_addr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_wait();
    tick();
    chk_cnt++;
    if (req_valid !== 1'b0)
      $display("FAIL rdw_in_wait: got req=%b expected 0", req_valid);
    else pass_cnt++;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if ({if_valid, req_valid} !== 2'b00)
      $display("FAIL rdw_still_wait: got if_valid=%b req=%b expected 0 0", if_valid, req_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h100})
      $display("FAIL rdw_dropped: got %b %b %h expected 0 1 00000100", if_valid, req_valid, req_addr);
    else pass_cnt++;
  endtask

  task automatic test_redirect_hold();
    repeat (2) tick();
    chk_cnt++;
    if ({if_valid, req_valid} !== 2'b00)
      $display("FAIL rdo_wait: got if_valid=%b req=%b expected 0 0", if_valid, req_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({if_valid, if_instr, if_pc} !== {1'b1, 32'h0000_0113, 32'h100})
      $display("FAIL rdo_deliver: got %b %h %h expected 1 00000113 00000100", if_valid, if_instr, if_pc);
    else pass_cnt++;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++;
    if ({if_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h40})
      $display("FAIL rdo_flush: got %b %b %h expected 0 1 00000040", if_valid, req_valid, req_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    tick();
    chk_cnt++;
    if ({req2_valid, req2_addr} !== {1'b0, 32'hFFFF_FFFC})
      $display("FAIL wrap_reset: got %b %h expected 0 fffffffc", req2_valid, req2_addr);
    else pass_cnt++;
    rst2_n = 1'b1;
    tick();
    chk_cnt++;
    if ({req2_valid, req2_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_first_req: got %b %h expected 1 fffffffc", req2_valid, req2_addr);
    else pass_cnt++;
    tick();
    rsp2_valid = 1'b1;
    rsp2_data  = 32'hAAAA_0013;
    tick();
    rsp2_valid = 1'b0;
    chk_cnt++;
    if ({if2_valid, if2_instr, if2_pc} !== {1'b1, 32'hAAAA_0013, 32'hFFFF_FFFC})
      $display("FAIL wrap_deliver: got %b %h %h expected 1 aaaa0013 fffffffc", if2_valid, if2_instr, if2_pc);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({req2_valid, req2_addr} !== {1'b1, 32'h0})
      $display("FAIL wrap_pc: got %b %h expected 1 00000000", req2_valid, req2_addr);
    else pass_cnt++;
    tick();
    rst2_n = 1'b0;
    #1;
    chk_cnt++;
    if ({req2_valid, req2_addr, if2_valid} !== {1'b0, 32'hFFFF_FFFC, 1'b0})
      $display("FAIL midwait_reset: got %b %h %b expected 0 fffffffc 0", req2_valid, req2_addr, if2_valid);
    else pass_cnt++;
    tick();
    rst2_n     = 1'b1;
    rsp2_valid = 1'b1;
    rsp2_data  = 32'hDEAD_BEEF;
    tick();
    rsp2_valid = 1'b0;
    chk_cnt++;
    if ({if2_valid, req2_valid, req2_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC})
      $display("FAIL stale_rsp: got %b %b %h expected 0 1 fffffffc", if2_valid, req2_valid, req2_addr);
    else pass_cnt++;
  endtask

  initial begin
    clk = 1'b0;
    pass_cnt = 0;
    chk_cnt  = 0;
    lat      = 1;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'h0; if_ready = 1'b0;
    rst2_n = 1'b0; redirect2_valid = 1'b0; redirect2_target = 32'h0;
    req2_ready = 1'b1; rsp2_valid = 1'b0; rsp2_data = 32'h0; if2_ready = 1'b1;

    test_reset();
    test_first_fetch();
    test_decode_stall();
    test_back_to_back();
    test_redirect_handshake();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap_and_reset();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
